// File: rtl/alu_divider_if.sv
// Request/result bundle for the 8-by-4 unsigned divider.
// Handshake: start is a request that is accepted only when the divider is idle.
// done pulses for one cycle, and quotient/remainder/div_by_zero are valid in that cycle.
// The results then hold until the next completion.
interface alu_divider_if;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/alu_divider.sv
// Sequential restoring divider: 8-bit dividend / 4-bit divisor, one quotient bit per clock.
// A zero divisor bypasses the iteration and reports saturated results.
module alu_divider (
  input  logic        clock,
  input  logic        resetn,
  alu_divider_if.slave bus,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] dvd_q;
  logic [3:0] dvs_q;
  logic [3:0] part_q;
  logic [7:0] quo_q;
  logic [2:0] count_q;

  logic [4:0] shifted;
  logic [4:0] diff;
  logic       take;
  logic [3:0] next_part;
  logic [7:0] next_quo;

  assign fsm_state = state;

  // The partial remainder always stays below the divisor, so 4 stored bits suffice.
  // Only the shifted value needs the extra fifth bit.
  always_comb begin
    shifted   = {part_q, dvd_q[7]};
    diff      = shifted - {1'b0, dvs_q};
    take      = (shifted >= {1'b0, dvs_q});
    next_part = take ? diff[3:0] : shifted[3:0];
    next_quo  = {quo_q[6:0], take};
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state           <= IDLE;
      dvd_q           <= 8'h00;
      dvs_q           <= 4'h0;
      part_q          <= 4'h0;
      quo_q           <= 8'h00;
      count_q         <= 3'd0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= 8'h00;
      bus.remainder   <= 4'h0;
      bus.div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.divisor == 4'h0) begin
              state           <= DONE;
              bus.done        <= 1'b1;
              bus.quotient    <= 8'hFF;
              bus.remainder   <= bus.dividend[3:0];
              bus.div_by_zero <= 1'b1;
            end else begin
              state    <= RUN;
              bus.busy <= 1'b1;
              dvd_q    <= bus.dividend;
              dvs_q    <= bus.divisor;
              part_q   <= 4'h0;
              quo_q    <= 8'h00;
              count_q  <= 3'd0;
            end
          end
        end
        RUN: begin
          dvd_q   <= {dvd_q[6:0], 1'b0};
          part_q  <= next_part;
          quo_q   <= next_quo;
          count_q <= count_q + 3'd1;
          // The eighth step publishes its own result directly, not via quo_q/part_q.
          if (count_q == 3'd7) begin
            state           <= DONE;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b1;
            bus.quotient    <= next_quo;
            bus.remainder   <= next_part;
            bus.div_by_zero <= 1'b0;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.done <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_divider.md
ALU_DIVIDER -- requirements
Module: alu_divider

Interface
REQ-001 SHALL have port clock, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: request a division; sampled on the rising clock edge.
REQ-004 SHALL have port dividend, input, 8 bits: unsigned numerator; sampled only when start is accepted.
REQ-005 SHALL have port divisor, input, 4 bits: unsigned denominator; sampled only when start is accepted.
REQ-006 SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse marking valid results.
REQ-008 SHALL have port quotient, output, 8 bits: registered unsigned quotient.
REQ-009 SHALL have port remainder, output, 4 bits: registered unsigned remainder.
REQ-010 SHALL have port div_by_zero, output, 1 bit: registered flag set when the last accepted divisor was 0.

Function
REQ-011 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-012 SHALL accept start only in IDLE; start in RUN or DONE SHALL be ignored with no effect on operands or results.
REQ-013 On an accepted start with divisor != 0, SHALL latch both operands, clear the iteration count, enter RUN and assert busy from the next cycle.
REQ-014 In RUN, SHALL perform one restoring-division step per clock, MSB of dividend first.
REQ-015 Each restoring step SHALL shift {partial, next dividend bit} into a 5-bit partial remainder, subtract the zero-extended divisor when partial >= divisor, and shift the comparison result into the quotient LSB.
REQ-016 RUN SHALL last exactly 8 clock edges; on the 8th edge quotient and remainder SHALL be loaded, div_by_zero cleared, state set to DONE and busy deasserted.
REQ-017 Latency: with start accepted at edge k, done SHALL be high during the cycle after edge k+8, and state SHALL return to IDLE at edge k+9.
REQ-018 On an accepted start with divisor == 0, SHALL skip RUN and go directly to DONE at that edge with quotient = 8'hFF, remainder = dividend[3:0] and div_by_zero = 1.
REQ-019 For divisor == 0, busy SHALL never assert and done SHALL pulse in the cycle after the accept edge.
REQ-020 quotient, remainder and div_by_zero SHALL change only on a DONE entry edge or on reset, and SHALL hold their values through IDLE until the next completion.
REQ-021 busy SHALL be high exactly when the state is RUN; done SHALL be high exactly when the state is DONE; both SHALL be registered-state decodes with no combinational path from start.
REQ-022 Results SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor for every divisor in 1..15 and every dividend in 0..255.
REQ-023 The 8-bit quotient SHALL never overflow, since divisor >= 1.
REQ-024 Changes on dividend or divisor while in RUN SHALL NOT affect the result in progress.

Reset
REQ-025 resetn low SHALL immediately, without waiting for a clock, force state to IDLE, busy = 0, done = 0, quotient = 8'h00, remainder = 4'h0, div_by_zero = 0, and clear all internal operand, partial-remainder and count registers.
REQ-026 Reset asserted mid-RUN SHALL abandon the division; no done pulse SHALL follow.
REQ-027 After resetn rises, the first start sampled high on a rising edge SHALL be accepted normally.

Verification
REQ-028 Basic division: dividend = 200, divisor = 7, start pulsed at edge k -> busy high for 8 cycles; done high after edge k+8; quotient = 28, remainder = 4, div_by_zero = 0.
REQ-029 Boundary values: 255/15 -> quotient = 17, remainder = 0; 5/9 -> quotient = 0, remainder = 5; 0/1 -> quotient = 0, remainder = 0; 255/1 -> quotient = 255, remainder = 0.
REQ-030 Divide by zero: dividend = 8'h3C, divisor = 0 -> no busy; done the cycle after accept; quotient = 8'hFF, remainder = 4'hC, div_by_zero = 1; a following 9/3 SHALL clear div_by_zero and give quotient = 3, remainder = 0.
REQ-031 Protocol and operand stability: start held high and operands changed during RUN of 100/6 -> result still quotient = 16, remainder = 4; start held high continuously -> a new division begins only from IDLE, one cycle after DONE.
REQ-032 Reset mid-operation: resetn pulsed low at the 4th RUN cycle -> all outputs 0 asynchronously and no done pulse; a subsequent 50/5 -> quotient = 10, remainder = 0.
REQ-033 Exhaustive check: the bench SHALL check all 256 x 16 operand pairs against REQ-022 and REQ-018.
